// File: rtl/vga_grid_pkg.sv
// Palette definitions and default VGA 640x480 timing shared by the grid painter.
package vga_grid_pkg;

    typedef logic [2:0] pal_idx_t;

    localparam pal_idx_t PAL_BLACK   = 3'd0;
    localparam pal_idx_t PAL_RED     = 3'd1;
    localparam pal_idx_t PAL_GREEN   = 3'd2;
    localparam pal_idx_t PAL_BLUE    = 3'd3;
    localparam pal_idx_t PAL_YELLOW  = 3'd4;
    localparam pal_idx_t PAL_CYAN    = 3'd5;
    localparam pal_idx_t PAL_MAGENTA = 3'd6;
    localparam pal_idx_t PAL_WHITE   = 3'd7;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_CLK_DIV  = 2;

    // {r,g,b} channel enables; each channel is driven all-0 or all-1
    function automatic logic [2:0] pal_rgb(input pal_idx_t idx);
        case (idx)
            PAL_BLACK:   pal_rgb = 3'b000;
            PAL_RED:     pal_rgb = 3'b100;
            PAL_GREEN:   pal_rgb = 3'b010;
            PAL_BLUE:    pal_rgb = 3'b001;
            PAL_YELLOW:  pal_rgb = 3'b110;
            PAL_CYAN:    pal_rgb = 3'b011;
            PAL_MAGENTA: pal_rgb = 3'b101;
            PAL_WHITE:   pal_rgb = 3'b111;
            default:     pal_rgb = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-rate enable, x/y raster counters, raw syncs and video_on decode.
module vga_timing_gen
    import vga_grid_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int CLK_DIV  = VGA_CLK_DIV,
    parameter bit SYNC_POL = 1'b0,
    parameter int XW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int YW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          pix_ce,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          video_on,
    output logic          hsync_raw,
    output logic          vsync_raw
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_next;

    // pix_ce is registered so it stays low throughout reset
    assign div_next = (div_cnt == '0) ? DIV_LAST : div_cnt - DW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= DIV_LAST;
            pix_ce  <= 1'b0;
        end else begin
            div_cnt <= div_next;
            pix_ce  <= (div_next == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (pix_ce) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    assign hsync_raw = ((x >= HS_START) && (x < HS_END)) ? SYNC_POL : ~SYNC_POL;
    assign vsync_raw = ((y >= VS_START) && (y < VS_END)) ? SYNC_POL : ~SYNC_POL;
    assign video_on  = (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));

endmodule

// File: rtl/vga_grid_painter.sv
// VGA grid painter: screen split into GRID_COLS x GRID_ROWS regions, per-region palette
// edited by buttons. Optional selection border when VGA_GRID_CURSOR_EN is defined.
module vga_grid_painter
    import vga_grid_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter int CLK_DIV   = VGA_CLK_DIV,
    parameter int GRID_COLS = 2,
    parameter int GRID_ROWS = 2,
    parameter int COLOR_W   = 8,
    parameter bit SYNC_POL  = 1'b0,
    localparam int RW = (GRID_COLS * GRID_ROWS > 1) ? $clog2(GRID_COLS * GRID_ROWS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_region,
    input  logic               btn_color,
    input  logic               btn_clear,
    output logic               hsync,
    output logic               vsync,
    output logic               n_sync,
    output logic               n_blanc,
    output logic               pix_ce,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic [RW-1:0]      region_sel,
    output logic               frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW       = $clog2(H_TOTAL);
    localparam int YW       = $clog2(V_TOTAL);
    localparam int N_REG    = GRID_COLS * GRID_ROWS;
    localparam int REGION_W = H_ACTIVE / GRID_COLS;
    localparam int REGION_H = V_ACTIVE / GRID_ROWS;
    localparam int CW       = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
    localparam int ROWW     = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
    localparam int HCW      = (REGION_W > 1) ? $clog2(REGION_W) : 1;
    localparam int VCW      = (REGION_H > 1) ? $clog2(REGION_H) : 1;

    localparam logic [XW-1:0]   X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0]   Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [HCW-1:0]  H_RELOAD = HCW'(REGION_W - 1);
    localparam logic [VCW-1:0]  V_RELOAD = VCW'(REGION_H - 1);
    localparam logic [CW-1:0]   COL_LAST = CW'(GRID_COLS - 1);
    localparam logic [ROWW-1:0] ROW_LAST = ROWW'(GRID_ROWS - 1);
    localparam logic [RW-1:0]   SEL_LAST = RW'(N_REG - 1);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          video_on;
    logic          hs_raw;
    logic          vs_raw;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CLK_DIV(CLK_DIV), .SYNC_POL(SYNC_POL), .XW(XW), .YW(YW)
    ) u_timing (
        .clk      (clk),
        .reset    (reset),
        .pix_ce   (pix_ce),
        .x        (x),
        .y        (y),
        .video_on (video_on),
        .hsync_raw(hs_raw),
        .vsync_raw(vs_raw)
    );

    assign n_sync = 1'b0;

    // Column/row trackers: down-counters reload at each region edge, clamped at the last cell
    logic [CW-1:0]   col;
    logic [ROWW-1:0] row;
    logic [HCW-1:0]  h_cnt;
    logic [VCW-1:0]  v_cnt;
    logic [RW-1:0]   region;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col   <= '0;
            row   <= '0;
            h_cnt <= H_RELOAD;
            v_cnt <= V_RELOAD;
        end else if (pix_ce) begin
            if (x == X_LAST) begin
                col   <= '0;
                h_cnt <= H_RELOAD;
                if (y == Y_LAST) begin
                    row   <= '0;
                    v_cnt <= V_RELOAD;
                end else if (v_cnt == '0) begin
                    v_cnt <= V_RELOAD;
                    if (row != ROW_LAST) row <= row + ROWW'(1);
                end else begin
                    v_cnt <= v_cnt - VCW'(1);
                end
            end else if (h_cnt == '0) begin
                h_cnt <= H_RELOAD;
                if (col != COL_LAST) col <= col + CW'(1);
            end else begin
                h_cnt <= h_cnt - HCW'(1);
            end
        end
    end

    assign region = RW'(row) * RW'(GRID_COLS) + RW'(col);

    // Button synchronisers; edges are masked until the sync chain has filled after reset
    logic [2:0] btn_raw;
    logic [2:0] btn_s1;
    logic [2:0] btn_s2;
    logic [2:0] btn_prev;
    logic [2:0] btn_edge;
    logic [1:0] arm_cnt;

    assign btn_raw = {btn_region, btn_color, btn_clear};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_prev <= '0;
            arm_cnt  <= 2'd3;
        end else begin
            btn_s1   <= btn_raw;
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
            if (arm_cnt != 2'd0) arm_cnt <= arm_cnt - 2'd1;
        end
    end

    assign btn_edge = (arm_cnt == 2'd0) ? (btn_s2 & ~btn_prev) : 3'b000;

    logic [RW-1:0] sel;
    pal_idx_t      pal [N_REG];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel <= '0;
        end else if (btn_edge[2]) begin
            sel <= (sel == SEL_LAST) ? '0 : sel + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_REG; i++) pal[i] <= 3'((i + 1) % 8);
        end else if (btn_edge[0]) begin
            for (int i = 0; i < N_REG; i++) pal[i] <= 3'((i + 1) % 8);
        end else if (btn_edge[1]) begin
            pal[region_sel] <= pal[region_sel] + 3'd1;
        end
    end

    logic [RW-1:0] s1_region;
    logic          s1_video;
    logic          s1_hs;
    logic          s1_vs;
    logic          s1_frame;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_region <= '0;
            s1_video  <= 1'b0;
            s1_hs     <= ~SYNC_POL;
            s1_vs     <= ~SYNC_POL;
            s1_frame  <= 1'b0;
        end else if (pix_ce) begin
            s1_region <= region;
            s1_video  <= video_on;
            s1_hs     <= hs_raw;
            s1_vs     <= vs_raw;
            s1_frame  <= (x == '0) && (y == '0);
        end
    end

`ifdef VGA_GRID_CURSOR_EN
    localparam logic [HCW-1:0] H_EDGE_HI = HCW'(REGION_W - 3);
    localparam logic [VCW-1:0] V_EDGE_HI = VCW'(REGION_H - 3);

    logic s1_edge;

    // Outermost two pixels of a region on any side
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_edge <= 1'b0;
        end else if (pix_ce) begin
            s1_edge <= (h_cnt < HCW'(2)) || (h_cnt > H_EDGE_HI) ||
                       (v_cnt < VCW'(2)) || (v_cnt > V_EDGE_HI);
        end
    end
`endif

    logic [2:0] rgb_en;

    always_comb begin
        rgb_en = pal_rgb(pal[s1_region]);
`ifdef VGA_GRID_CURSOR_EN
        if (s1_edge && (s1_region == region_sel)) rgb_en = 3'b111;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            n_blanc     <= 1'b0;
            frame_start <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            region_sel  <= '0;
        end else if (pix_ce) begin
            hsync       <= s1_hs;
            vsync       <= s1_vs;
            n_blanc     <= s1_video;
            frame_start <= s1_frame;
            r           <= s1_video ? {COLOR_W{rgb_en[2]}} : '0;
            g           <= s1_video ? {COLOR_W{rgb_en[1]}} : '0;
            b           <= s1_video ? {COLOR_W{rgb_en[0]}} : '0;
            if (s1_frame) region_sel <= sel;
        end
    end

endmodule
